// File: rtl/sram_data_arbiter.sv
// sram_data_arbiter: shares SRAM port 0 between core and fabric; ports: core_*/fab_* req/gnt/rvalid requesters, sram_*0 macro controls, fab_forced_o starvation pulse
module sram_data_arbiter #(
  parameter int FAB_MAX_WAIT = 4,
  parameter int WORDS = 256
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        core_req_i,
  output logic        core_gnt_o,
  input  logic        core_we_i,
  input  logic [3:0]  core_be_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wdata_i,
  output logic        core_rvalid_o,
  output logic        core_err_o,
  output logic [31:0] core_rdata_o,
  input  logic        fab_req_i,
  output logic        fab_gnt_o,
  input  logic        fab_we_i,
  input  logic [3:0]  fab_be_i,
  input  logic [31:0] fab_addr_i,
  input  logic [31:0] fab_wdata_i,
  output logic        fab_rvalid_o,
  output logic        fab_err_o,
  output logic [31:0] fab_rdata_o,
  output logic        sram_csb0_o,
  output logic        sram_web0_o,
  output logic [3:0]  sram_wmask0_o,
  output logic [7:0]  sram_addr0_o,
  output logic [31:0] sram_din0_o,
  input  logic [31:0] sram_dout0_i,
  output logic        fab_forced_o
);
  localparam int AW = $clog2(WORDS);
  logic [3:0] wait_cnt;
  logic core_pend, fab_pend, err_q, rd_q;
  logic any_gnt, s_we, oor;
  logic [3:0] s_be;
  logic [31:0] s_addr, s_wdata;
  always_comb begin
    fab_forced_o = resetn && fab_req_i && wait_cnt == 4'(FAB_MAX_WAIT);
    fab_gnt_o = resetn && fab_req_i && (!core_req_i || fab_forced_o);
    core_gnt_o = resetn && core_req_i && !fab_gnt_o;
    any_gnt = fab_gnt_o || core_gnt_o;
    s_we = fab_gnt_o ? fab_we_i : core_we_i;
    s_be = fab_gnt_o ? fab_be_i : core_be_i;
    s_addr = fab_gnt_o ? fab_addr_i : core_addr_i;
    s_wdata = fab_gnt_o ? fab_wdata_i : core_wdata_i;
    oor = |(s_addr >> (AW + 2));
    sram_csb0_o = !(any_gnt && !oor);
    sram_web0_o = !(any_gnt && s_we);
    sram_wmask0_o = any_gnt && s_we ? s_be : 4'h0;
    sram_addr0_o = any_gnt ? s_addr[AW+1:2] : '0;
    sram_din0_o = any_gnt ? s_wdata : 32'h0;
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      wait_cnt <= 4'h0;
      core_pend <= 1'b0;
      fab_pend <= 1'b0;
      err_q <= 1'b0;
      rd_q <= 1'b0;
    end else begin
      wait_cnt <= !fab_req_i || fab_gnt_o ? 4'h0 :
                  wait_cnt == 4'(FAB_MAX_WAIT) ? wait_cnt : wait_cnt + 4'h1;
      core_pend <= core_gnt_o;
      fab_pend <= fab_gnt_o;
      err_q <= any_gnt && oor;
      rd_q <= any_gnt && !s_we && !oor;
    end
  assign core_rvalid_o = core_pend;
  assign core_err_o = core_pend && err_q;
  assign core_rdata_o = core_pend && rd_q ? sram_dout0_i : 32'h0;
  assign fab_rvalid_o = fab_pend;
  assign fab_err_o = fab_pend && err_q;
  assign fab_rdata_o = fab_pend && rd_q ? sram_dout0_i : 32'h0;
endmodule

// File: tb/tb_sram_data_arbiter.sv
// tb_sram_data_arbiter: randomized and directed check of sram_data_arbiter against a transaction-level model
module tb_sram_data_arbiter;
  localparam int MAXW = 4;
  logic clk = 1'b0, resetn = 1'b0;
  logic core_req_i = 0, core_we_i = 0, fab_req_i = 0, fab_we_i = 0;
  logic [3:0] core_be_i = 0, fab_be_i = 0;
  logic [31:0] core_addr_i = 0, core_wdata_i = 0, fab_addr_i = 0, fab_wdata_i = 0, sram_dout0_i = 0;
  logic core_gnt_o, core_rvalid_o, core_err_o, fab_gnt_o, fab_rvalid_o, fab_err_o;
  logic [31:0] core_rdata_o, fab_rdata_o, sram_din0_o;
  logic sram_csb0_o, sram_web0_o, fab_forced_o;
  logic [3:0] sram_wmask0_o;
  logic [7:0] sram_addr0_o;
  int nvec = 0, nerr = 0;
  int owner = 0, m_cnt = 0;
  bit m_err = 0, m_rd = 0, e_cg = 0, e_fg = 0;
  sram_data_arbiter #(.FAB_MAX_WAIT(MAXW), .WORDS(256)) dut (
    .clk(clk), .resetn(resetn),
    .core_req_i(core_req_i), .core_gnt_o(core_gnt_o), .core_we_i(core_we_i), .core_be_i(core_be_i),
    .core_addr_i(core_addr_i), .core_wdata_i(core_wdata_i), .core_rvalid_o(core_rvalid_o),
    .core_err_o(core_err_o), .core_rdata_o(core_rdata_o),
    .fab_req_i(fab_req_i), .fab_gnt_o(fab_gnt_o), .fab_we_i(fab_we_i), .fab_be_i(fab_be_i),
    .fab_addr_i(fab_addr_i), .fab_wdata_i(fab_wdata_i), .fab_rvalid_o(fab_rvalid_o),
    .fab_err_o(fab_err_o), .fab_rdata_o(fab_rdata_o),
    .sram_csb0_o(sram_csb0_o), .sram_web0_o(sram_web0_o), .sram_wmask0_o(sram_wmask0_o),
    .sram_addr0_o(sram_addr0_o), .sram_din0_o(sram_din0_o), .sram_dout0_i(sram_dout0_i),
    .fab_forced_o(fab_forced_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic drive(input bit cr, input bit cw, input logic [3:0] cb, input logic [31:0] ca, input logic [31:0] cd,
                       input bit fr, input bit fw, input logic [3:0] fb, input logic [31:0] fa, input logic [31:0] fd);
    core_req_i = cr; core_we_i = cw; core_be_i = cb; core_addr_i = ca; core_wdata_i = cd;
    fab_req_i = fr; fab_we_i = fw; fab_be_i = fb; fab_addr_i = fa; fab_wdata_i = fd;
  endtask
  // owner: 0 none, 1 core, 2 fabric -- the requester whose response is due this cycle
  task automatic step();
    bit forced, win, we, oor;
    logic [3:0] be;
    logic [31:0] addr, wd, dout;
    dout = $urandom;
    sram_dout0_i = dout;
    if (!resetn) begin owner = 0; m_cnt = 0; m_err = 0; m_rd = 0; end
    forced = resetn && fab_req_i && m_cnt == MAXW;
    e_fg = resetn && fab_req_i && (forced || !core_req_i);
    e_cg = resetn && core_req_i && !e_fg;
    win = e_cg || e_fg;
    we = e_fg ? fab_we_i : core_we_i;
    be = e_fg ? fab_be_i : core_be_i;
    addr = e_fg ? fab_addr_i : core_addr_i;
    wd = e_fg ? fab_wdata_i : core_wdata_i;
    oor = addr >= 32'h400;
    #1;
    chk("core_gnt", core_gnt_o, e_cg);
    chk("fab_gnt", fab_gnt_o, e_fg);
    chk("forced", fab_forced_o, forced);
    chk("csb", sram_csb0_o, !(win && !oor));
    chk("web", sram_web0_o, !(win && we));
    chk("wmask", sram_wmask0_o, (win && we) ? be : 4'h0);
    chk("addr0", sram_addr0_o, win ? (addr / 4) % 256 : 0);
    chk("din", sram_din0_o, win ? wd : 0);
    chk("core_rvalid", core_rvalid_o, owner == 1);
    chk("core_err", core_err_o, owner == 1 && m_err);
    chk("core_rdata", core_rdata_o, (owner == 1 && m_rd) ? dout : 0);
    chk("fab_rvalid", fab_rvalid_o, owner == 2);
    chk("fab_err", fab_err_o, owner == 2 && m_err);
    chk("fab_rdata", fab_rdata_o, (owner == 2 && m_rd) ? dout : 0);
    @(posedge clk);
    if (resetn) begin
      owner = e_cg ? 1 : e_fg ? 2 : 0;
      m_err = win && oor;
      m_rd = win && !we && !oor;
      if (!fab_req_i || e_fg) m_cnt = 0;
      else if (m_cnt < MAXW) m_cnt++;
    end
    #1;
  endtask
  function automatic logic [31:0] rnd_addr();
    logic [31:0] a;
    a = $urandom;
    return ($urandom_range(0, 7) == 0) ? a : (a & 32'h3FF);
  endfunction
  initial begin
    step();
    @(posedge clk); #1;
    resetn = 1'b1;
    drive(1, 0, 4'hF, 32'h10, 0, 0, 0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0, 1, 1, 4'b0011, 32'h3FC, 32'h12345678); step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step();
    for (int i = 0; i < 12; i++) begin
      drive(1, 0, 4'hF, 32'h20 + 4 * i, 0, 1, 0, 4'hF, 32'h100, 0);
      step();
    end
    drive(1, 0, 4'hF, 32'h400, 0, 0, 0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step();
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) drive(1, 0, 4'hF, 32'h8, 0, 0, 0, 0, 0, 0);
      else drive(0, 0, 0, 0, 0, 1, 0, 4'hF, 32'hC, 0);
      step();
    end
    drive(1, 0, 4'hF, 32'h8, 0, 0, 0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    resetn = 1'b0; step();
    resetn = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (!(core_req_i && !e_cg))
        drive($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, 4'($urandom), rnd_addr(), $urandom,
              fab_req_i, fab_we_i, fab_be_i, fab_addr_i, fab_wdata_i);
      if (!(fab_req_i && !e_fg)) begin
        fab_req_i = $urandom_range(0, 2) != 0;
        fab_we_i = $urandom_range(0, 1) == 1;
        fab_be_i = 4'($urandom);
        fab_addr_i = rnd_addr();
        fab_wdata_i = $urandom;
      end
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
